// File: rtl/code_lock_ctrl_pkg.sv
// Shared definitions for the code lock: FSM state encoding (also the display
// state code) and the hex-to-seven-segment table (active-low, {g..a}).
package code_lock_ctrl_pkg;

    localparam logic [2:0] ST_ENTRY   = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_NEWCODE = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg_on;
        case (hex)
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            default: seg_on = 7'h71;
        endcase
        return ~seg_on;
    endfunction

endpackage

// File: rtl/code_lock_ctrl_ssd_scan.sv
// Four-digit multiplexed hex display driver: one anode low at a time, stepping
// every SCAN_DIV clocks; AN[3] shows word[15:12].
module ssd_scan
    import code_lock_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [15:0] word,
    output logic [3:0]  AN,
    output logic [6:0]  seven_out
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       nibble;

    always_comb begin
        div_d = div_q;
        sel_d = sel_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            sel_d = sel_q + 2'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            sel_q <= 2'd0;
        end else begin
            div_q <= div_d;
            sel_q <= sel_d;
        end
    end

    assign nibble    = word[{sel_q, 2'b00} +: 4];
    assign AN        = ~(4'b0001 << sel_q);
    assign seven_out = hex_to_seg(nibble);

endmodule

// File: rtl/code_lock_ctrl.sv
// Digit-code lock controller with retry lockout, code change and hex status display.
// Optional build macro CODE_LOCK_BACKDOOR_EN also accepts MASTER_CODE on a check.
module code_lock_ctrl
    import code_lock_ctrl_pkg::*;
#(
    parameter int DIGIT_W     = 8,
    parameter int NUM_DIGITS  = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 16,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] RESET_CODE  = 32'h01020304,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] MASTER_CODE = '1,
    parameter int SCAN_DIV    = 4
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               clr,
    input  logic               ent,
    input  logic               change,
    input  logic [DIGIT_W-1:0] sw,
    output logic [5:0]         led,
    output logic [3:0]         AN,
    output logic [6:0]         seven_out
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W  = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [1:0] MAX_T    = 2'(MAX_TRIES);
    localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);

    logic [2:0]        state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [1:0]        tries_q, tries_d;
    logic              fail_q, fail_d;
    logic [CODE_W-1:0] buf_q, buf_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              clr_prev_q, ent_prev_q, change_prev_q;
    logic              armed_q;

    logic              clr_ev, ent_ev, change_ev;
    logic [CODE_W-1:0] buf_cap;
    logic [1:0]        tries_inc;
    logic              match;

    // armed_q masks the first cycle after reset so a button held through
    // release does not look like a fresh press.
    assign clr_ev    = armed_q & clr & ~clr_prev_q;
    assign ent_ev    = armed_q & ent & ~ent_prev_q & ~clr_ev;
    assign change_ev = armed_q & change & ~change_prev_q & ~clr_ev & ~ent_ev;

`ifdef CODE_LOCK_BACKDOOR_EN
    assign match = (buf_q == code_q) || (buf_q == MASTER_CODE);
`else
    logic unused_master;
    assign unused_master = ^MASTER_CODE;
    assign match = (buf_q == code_q);
`endif

    assign tries_inc = (tries_q == MAX_T) ? tries_q : tries_q + 2'd1;

    always_comb begin
        buf_cap = buf_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 4'(i)) begin
                buf_cap[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sw;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        fail_d  = fail_q;
        buf_d   = buf_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ENTRY, ST_NEWCODE: begin
                if (clr_ev) begin
                    idx_d  = 4'd0;
                    buf_d  = '0;
                    fail_d = 1'b0;
                end else if (ent_ev) begin
                    buf_d = buf_cap;
                    if (idx_q == LAST_IDX) begin
                        idx_d = 4'd0;
                        if (state_q == ST_ENTRY) begin
                            state_d = ST_CHECK;
                        end else begin
                            code_d  = buf_cap;
                            state_d = ST_OPEN;
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CHECK: begin
                cnt_d = '0;
                if (match) begin
                    tries_d = 2'd0;
                    fail_d  = 1'b0;
                    state_d = ST_OPEN;
                end else begin
                    tries_d = tries_inc;
                    fail_d  = 1'b1;
                    state_d = (tries_inc == MAX_T) ? ST_LOCKOUT : ST_ENTRY;
                end
            end
            ST_OPEN: begin
                if (clr_ev) begin
                    idx_d   = 4'd0;
                    buf_d   = '0;
                    state_d = ST_ENTRY;
                end else if (change_ev) begin
                    idx_d   = 4'd0;
                    buf_d   = '0;
                    state_d = ST_NEWCODE;
                end
            end
            ST_LOCKOUT: begin
                if (cnt_q == CNT_W'(LOCKOUT_CYC - 1)) begin
                    tries_d = 2'd0;
                    fail_d  = 1'b0;
                    state_d = ST_ENTRY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q       <= ST_ENTRY;
            idx_q         <= 4'd0;
            tries_q       <= 2'd0;
            fail_q        <= 1'b0;
            buf_q         <= '0;
            code_q        <= RESET_CODE;
            cnt_q         <= '0;
            clr_prev_q    <= 1'b0;
            ent_prev_q    <= 1'b0;
            change_prev_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            tries_q       <= tries_d;
            fail_q        <= fail_d;
            buf_q         <= buf_d;
            code_q        <= code_d;
            cnt_q         <= cnt_d;
            clr_prev_q    <= clr;
            ent_prev_q    <= ent;
            change_prev_q <= change;
            armed_q       <= 1'b1;
        end
    end

    assign led = {tries_q, fail_q, state_q == ST_NEWCODE,
                  state_q == ST_LOCKOUT, state_q == ST_OPEN};

    ssd_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk_in    (clk_in),
        .rst       (rst),
        .word      ({1'b0, state_q, 2'b00, tries_q, idx_q, 4'(sw)}),
        .AN        (AN),
        .seven_out (seven_out)
    );

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed self-checking bench for code_lock_ctrl at default parameters;
// the backdoor expectation follows CODE_LOCK_BACKDOOR_EN.
module tb_code_lock_ctrl;

    localparam logic [6:0] SEG0 = 7'h40;
    localparam logic [6:0] SEG2 = 7'h24;

    logic       clk_in = 1'b0;
    logic       rst, clr, ent, change;
    logic [7:0] sw;
    logic [5:0] led;
    logic [3:0] AN;
    logic [6:0] seven_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    code_lock_ctrl #(
        .DIGIT_W     (8),
        .NUM_DIGITS  (4),
        .MAX_TRIES   (3),
        .LOCKOUT_CYC (16),
        .RESET_CODE  (32'h01020304),
        .MASTER_CODE (32'hFFFFFFFF),
        .SCAN_DIV    (4)
    ) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .clr       (clr),
        .ent       (ent),
        .change    (change),
        .sw        (sw),
        .led       (led),
        .AN        (AN),
        .seven_out (seven_out)
    );

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic press_ent(input logic [7:0] v);
        @(negedge clk_in); sw = v; ent = 1'b1;
        @(negedge clk_in); ent = 1'b0;
    endtask

    task automatic press_clr();
        @(negedge clk_in); clr = 1'b1;
        @(negedge clk_in); clr = 1'b0;
    endtask

    task automatic press_change();
        @(negedge clk_in); change = 1'b1;
        @(negedge clk_in); change = 1'b0;
    endtask

    task automatic enter_code(input logic [31:0] c);
        for (int i = 0; i < 4; i++) press_ent(c[31-8*i -: 8]);
    endtask

    task automatic wait_an(input logic [3:0] an, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (AN === an) begin ok = 1'b1; break; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; clr = 1'b0; ent = 1'b0; change = 1'b0; sw = 8'h00;
        repeat (3) @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bit ok;
        rst = 1'b1; clr = 1'b0; ent = 1'b0; change = 1'b0; sw = 8'h00;
        @(negedge clk_in);
        checks++;
        if (led !== 6'b000000 || AN !== 4'b1110 || seven_out !== SEG0) begin
            failures++;
            $display("FAIL reset_outputs got led=%b AN=%b seg=%h exp led=000000 AN=1110 seg=%h",
                     led, AN, seven_out, SEG0);
        end
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        wait_an(4'b0111, ok);
        checks++;
        if (!ok || seven_out !== SEG0) begin
            failures++;
            $display("FAIL reset_state_digit got ok=%0d seg=%h exp seg=%h", ok, seven_out, SEG0);
        end
    endtask

    task automatic test_open();
        bit ok;
        enter_code(32'h01020304);
        checks++;
        if (led !== 6'b000000) begin
            failures++;
            $display("FAIL check_cycle_led got %b exp 000000", led);
        end
        @(negedge clk_in);
        checks++;
        if (led !== 6'b000001) begin
            failures++;
            $display("FAIL open_led got %b exp 000001", led);
        end
        wait_an(4'b0111, ok);
        checks++;
        if (!ok || seven_out !== SEG2) begin
            failures++;
            $display("FAIL open_state_digit got ok=%0d seg=%h exp seg=%h", ok, seven_out, SEG2);
        end
    endtask

    task automatic test_change_code();
        press_change();
        checks++;
        if (led !== 6'b000100) begin
            failures++;
            $display("FAIL newcode_led got %b exp 000100", led);
        end
        enter_code(32'hAABBCCDD);
        checks++;
        if (led !== 6'b000001) begin
            failures++;
            $display("FAIL newcode_done_led got %b exp 000001", led);
        end
        press_clr();
        checks++;
        if (led !== 6'b000000) begin
            failures++;
            $display("FAIL relock_led got %b exp 000000", led);
        end
        enter_code(32'h01020304);
        @(negedge clk_in);
        checks++;
        if (led !== 6'b011000) begin
            failures++;
            $display("FAIL old_code_rejected got %b exp 011000", led);
        end
        press_clr();
        checks++;
        if (led !== 6'b010000) begin
            failures++;
            $display("FAIL clr_clears_fail got %b exp 010000", led);
        end
        enter_code(32'hAABBCCDD);
        @(negedge clk_in);
        checks++;
        if (led !== 6'b000001) begin
            failures++;
            $display("FAIL new_code_opens got %b exp 000001", led);
        end
        press_clr();
    endtask

    task automatic test_lockout();
        logic [5:0] exp_led [3] = '{6'b011000, 6'b101000, 6'b111010};
        int cnt;
        bit ok;
        for (int k = 0; k < 3; k++) begin
            enter_code(32'h00000000);
            @(negedge clk_in);
            checks++;
            if (led !== exp_led[k]) begin
                failures++;
                $display("FAIL wrong_code_%0d got %b exp %b", k + 1, led, exp_led[k]);
            end
        end
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            ent = ~ent;
            @(negedge clk_in);
            if (led[1]) cnt++;
            else break;
        end
        ent = 1'b0;
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL lockout_length got %0d exp 16", cnt);
        end
        checks++;
        if (led !== 6'b000000) begin
            failures++;
            $display("FAIL after_lockout_led got %b exp 000000", led);
        end
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seven_out !== SEG0) begin
            failures++;
            $display("FAIL lockout_ent_ignored got ok=%0d seg=%h exp seg=%h", ok, seven_out, SEG0);
        end
    endtask

    task automatic test_clr_ent_coincident();
        bit ok;
        do_reset();
        press_ent(8'h01);
        press_ent(8'h02);
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seven_out !== SEG2) begin
            failures++;
            $display("FAIL idx_two got ok=%0d seg=%h exp seg=%h", ok, seven_out, SEG2);
        end
        @(negedge clk_in); sw = 8'h55; ent = 1'b1; clr = 1'b1;
        @(negedge clk_in); ent = 1'b0; clr = 1'b0;
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seven_out !== SEG0 || led !== 6'b000000) begin
            failures++;
            $display("FAIL clr_beats_ent got ok=%0d seg=%h led=%b exp seg=%h led=000000",
                     ok, seven_out, led, SEG0);
        end
        enter_code(32'h01020304);
        @(negedge clk_in);
        checks++;
        if (led !== 6'b000001) begin
            failures++;
            $display("FAIL after_clr_entry got %b exp 000001", led);
        end
        press_clr();
    endtask

    task automatic test_reset_mid_entry();
        bit ok;
        press_ent(8'h01);
        press_ent(8'h02);
        @(negedge clk_in); rst = 1'b1; ent = 1'b1;
        #1;
        checks++;
        if (AN !== 4'b1110 || led !== 6'b000000) begin
            failures++;
            $display("FAIL async_reset got AN=%b led=%b exp AN=1110 led=000000", AN, led);
        end
        repeat (2) @(negedge clk_in);
        rst = 1'b0;
        repeat (3) @(negedge clk_in);
        ent = 1'b0;
        wait_an(4'b1101, ok);
        checks++;
        if (!ok || seven_out !== SEG0) begin
            failures++;
            $display("FAIL held_button_no_event got ok=%0d seg=%h exp seg=%h", ok, seven_out, SEG0);
        end
        enter_code(32'h01020304);
        @(negedge clk_in);
        checks++;
        if (led !== 6'b000001) begin
            failures++;
            $display("FAIL reset_code_restored got %b exp 000001", led);
        end
    endtask

    task automatic test_backdoor();
        logic [5:0] exp;
`ifdef CODE_LOCK_BACKDOOR_EN
        exp = 6'b000001;
`else
        exp = 6'b111010;
`endif
        do_reset();
        enter_code(32'h00000000);
        @(negedge clk_in);
        enter_code(32'h00000000);
        @(negedge clk_in);
        checks++;
        if (led !== 6'b101000) begin
            failures++;
            $display("FAIL two_failures got %b exp 101000", led);
        end
        enter_code(32'hFFFFFFFF);
        @(negedge clk_in);
        checks++;
        if (led !== exp) begin
            failures++;
            $display("FAIL master_code got %b exp %b", led, exp);
        end
    endtask

    initial begin
        test_reset();
        test_open();
        test_change_code();
        test_lockout();
        test_clr_ent_coincident();
        test_reset_mid_entry();
        test_backdoor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/code_lock_ctrl.md
CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

Interface
REQ-001 Parameter DIGIT_W, default 8, meaning switch width per code digit.
REQ-002 Parameter NUM_DIGITS, default 4, meaning digits per code (1..8).
REQ-003 Parameter MAX_TRIES, default 3, meaning consecutive wrong codes before lockout (1..3).
REQ-004 Parameter LOCKOUT_CYC, default 16, meaning lockout duration in clk_in cycles.
REQ-005 Parameter RESET_CODE, default 32'h01020304, meaning code loaded at reset (NUM_DIGITS*DIGIT_W bits, first digit in MSBs).
REQ-006 Parameter SCAN_DIV, default 4, meaning clk_in cycles per display anode step.
REQ-007 Port clk_in, input, 1, the single clock; all logic on its rising edge.
REQ-008 Port rst, input, 1, reset, asynchronous and active-high.
REQ-009 Ports clr, ent, change, input, 1 each, debounced synchronous button levels; the block edge-detects them internally.
REQ-010 Port sw, input, DIGIT_W, digit value sampled on ent rising edge.
REQ-011 Port led, output, 6: [0] open, [1] lockout, [2] new-code mode, [3] last check failed, [5:4] tries used.
REQ-012 Port AN, output, 4, active-low anode select, exactly one bit low at a time.
REQ-013 Port seven_out, output, 7, active-low segments {g..a} for the selected digit.

Function
REQ-014 A button event is the one-cycle rising edge of its input; priority clr > ent > change when coincident; lower-priority events that cycle are dropped.
REQ-015 States: ENTRY, CHECK, OPEN, NEWCODE, LOCKOUT.
REQ-016 ENTRY: ent writes sw into buffer slot idx, idx increments; on capture of slot NUM_DIGITS-1, idx clears and next state is CHECK.
REQ-017 CHECK lasts exactly one cycle: match with stored code -> OPEN, tries=0, led[3]=0; mismatch -> tries+1, led[3]=1, then LOCKOUT if tries reaches MAX_TRIES, else ENTRY.
REQ-018 OPEN: clr -> ENTRY (relock); change -> NEWCODE; ent ignored.
REQ-019 NEWCODE: digit capture as in ENTRY; on last digit the stored code is replaced, the next state is OPEN.
REQ-020 clr in ENTRY or NEWCODE clears idx and buffer without state change and clears led[3].
REQ-021 LOCKOUT: all button events ignored; counter runs LOCKOUT_CYC cycles, then ENTRY with tries=0, led[3]=0.
REQ-022 tries saturates at MAX_TRIES; led[5:4] shows tries.
REQ-023 Display word {state code 4b, tries 4b, idx 4b, sw[3:0]} shown hex, AN[3] on MSB nibble; anode advances every SCAN_DIV cycles, wrapping 3->0.

Reset
REQ-024 On rst: state ENTRY, idx=0, tries=0, buffer=0, stored code=RESET_CODE, led=6'b0, AN=4'b1110, scan counter=0, edge-detect registers=0 (no spurious event after release if a button is held).
REQ-025 rst mid-entry or mid-lockout abandons the operation with no stored-code write.

Configuration
REQ-026 Macro CODE_LOCK_BACKDOOR_EN: when defined, parameter MASTER_CODE (default all ones) also matches in CHECK from ENTRY, giving OPEN and tries=0; master code is never overwritten by NEWCODE.
REQ-027 Without CODE_LOCK_BACKDOOR_EN, MASTER_CODE is ignored and only the stored code matches.

Structure
REQ-028 Shared package holds the state encoding (ENTRY=0, CHECK=1, OPEN=2, NEWCODE=3, LOCKOUT=4, shown as display state code) and the hex-to-segment table.
REQ-029 Display scanning is sub-module ssd_scan (16-bit word in, AN and seven_out out, SCAN_DIV parameter).

Verification (defaults: DIGIT_W=8, NUM_DIGITS=4, MAX_TRIES=3, LOCKOUT_CYC=16)
REQ-030 Enter 01,02,03,04 -> one cycle in CHECK, then led[0]=1, led[5:4]=0.
REQ-031 Three wrong codes 00,00,00,00 -> led[5:4] 1,2,3, then led[1]=1 for exactly 16 cycles, ents during lockout ignored, then ENTRY, tries=0.
REQ-032 From OPEN: change, enter AA,BB,CC,DD, clr, enter 01,02,03,04 -> fail (led[3]=1); enter AA,BB,CC,DD -> OPEN.
REQ-033 ent and clr rising same cycle after two digits -> idx=0, no digit captured; rst asserted after two digits -> display idx nibble 0, AN=4'b1110.
REQ-034 With CODE_LOCK_BACKDOOR_EN, entering FF,FF,FF,FF after two failures -> OPEN, tries=0; without macro -> third failure and LOCKOUT.
